// File: rtl/dmem_bridge.sv
// dmem_bridge: data-side bridge between the single-cycle core's combinational
// data port and a variable-latency req/ack data memory bus.
//
// Stores are posted through a one-entry write buffer, so the core only stalls
// when a second store arrives while the first one is still on the bus.
// Loads stall the core until the read word is back and held in drdata.
//
// Bus handshake: bus_req rises together with registered bus_we, bus_addr,
// bus_wdata and bus_be. All of them stay stable until the first rising clk
// edge where bus_ack=1. That edge completes the transaction and bus_req drops
// on it. bus_ack is ignored whenever bus_req=0.
module dmem_bridge #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [31:0]       dwdata,
    input  logic [3:0]        dwe,
    input  logic              dre,
    output logic [31:0]       drdata,
    output logic              hold,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    output logic [3:0]        bus_be,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata,
    output logic [CNT_W-1:0]  stall_cnt
);

    // IDLE: nothing on the bus; WR: buffered store in flight;
    // RD: load in flight; RDONE: read word held for the core to commit.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WR    = 2'd1,
        ST_RD    = 2'd2,
        ST_RDONE = 2'd3
    } state_t;

    state_t            state;
    logic              wbuf_valid;

    logic              store_req;
    logic              load_req;
    logic              store_accept;
    logic              load_start;
    logic [ADDR_W-1:0] word_addr;

    // The byte-lane bits of the address are dropped here on purpose.
    // The bus is word-addressed and the lanes travel in bus_be.
    logic              unused_lane_bits;
    assign unused_lane_bits = ^daddr[1:0];

    // A store wins over a simultaneous load strobe.
    assign store_req = |dwe;
    assign load_req  = dre & ~store_req;

    // Stall the core while a store finds the buffer occupied, or while a load
    // has not yet reached the cycle where its data is presented.
    assign hold = reset & ((store_req & wbuf_valid) |
                           (load_req & (state != ST_RDONE)));

    // A store commits on any edge where the core is not held. That implies
    // the buffer is free.
    assign store_accept = store_req & ~hold;

    // Loads launch only from an idle bus with an empty buffer.
    // This drains posted writes before any read.
    assign load_start = load_req & (state == ST_IDLE) & ~wbuf_valid;

    assign word_addr = {daddr[ADDR_W-1:2], 2'b00};

    // Transaction FSM: owns the write buffer, the registered bus outputs and drdata.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            wbuf_valid <= 1'b0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_be     <= 4'b0000;
            drdata     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (store_accept) begin
                        state      <= ST_WR;
                        wbuf_valid <= 1'b1;
                        bus_req    <= 1'b1;
                        bus_we     <= 1'b1;
                        bus_addr   <= word_addr;
                        bus_wdata  <= dwdata;
                        bus_be     <= dwe;
                    end else if (load_start) begin
                        state    <= ST_RD;
                        bus_req  <= 1'b1;
                        bus_we   <= 1'b0;
                        bus_addr <= word_addr;
                        bus_be   <= 4'b0000;
                    end
                end
                ST_WR: begin
                    if (bus_ack) begin
                        state      <= ST_IDLE;
                        wbuf_valid <= 1'b0;
                        bus_req    <= 1'b0;
                        bus_we     <= 1'b0;
                    end
                end
                ST_RD: begin
                    if (bus_ack) begin
                        state   <= ST_RDONE;
                        drdata  <= bus_rdata;
                        bus_req <= 1'b0;
                    end
                end
                ST_RDONE: begin
                    // The load commits on this edge. A store presented here
                    // is posted straight away, otherwise the bus goes idle.
                    if (store_accept) begin
                        state      <= ST_WR;
                        wbuf_valid <= 1'b1;
                        bus_req    <= 1'b1;
                        bus_we     <= 1'b1;
                        bus_addr   <= word_addr;
                        bus_wdata  <= dwdata;
                        bus_be     <= dwe;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Saturating count of core cycles lost to hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (hold && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule
